// File: rtl/vga_text_timing.sv
// vga_text_timing: VGA raster timing with a text-mode VRAM readout sequencer.
// Per cell it fetches the character byte, then the attribute byte.
// hSync/vSync/nVis are delayed by PIPE_DLY extra clocks so they line up
// with the downstream font/palette pipeline.
// Optional vertical scrolling is compiled in when VGA_TEXT_TIMING_SCROLL_EN is
// defined; otherwise scrollRow is ignored and the display starts at row 0.
module vga_text_timing #(
    parameter int H_VIS     = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VIS     = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CHAR_W    = 8,
    parameter int CHAR_H    = 16,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int PIPE_DLY  = 8,
    parameter int ADDR_W    = 13
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                scrollRow,
    output logic                      hSync,
    output logic                      vSync,
    output logic                      nVis,
    output logic                      active,
    output logic [ADDR_W-1:0]         readoutAddr,
    output logic [$clog2(CHAR_W)-1:0] readoutCount,
    output logic [$clog2(CHAR_H)-1:0] vCount,
    output logic                      frameStart
);

    localparam int HTOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int VTOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int COLS   = H_VIS / CHAR_W;
    localparam int HW     = $clog2(HTOTAL);
    localparam int VW     = $clog2(VTOTAL);
    localparam int PW     = $clog2(CHAR_W);
    localparam int LW     = $clog2(CHAR_H);
    localparam int CLW    = $clog2(HTOTAL / CHAR_W + 1);
    localparam int RW     = $clog2(VTOTAL / CHAR_H + 1);

    localparam logic [HW-1:0]     H_LAST     = HW'(HTOTAL - 1);
    localparam logic [HW-1:0]     H_VIS_C    = HW'(H_VIS);
    localparam logic [HW-1:0]     H_SS       = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0]     H_SE       = HW'(H_VIS + H_FP + H_SYNC);
    localparam logic [VW-1:0]     V_LAST     = VW'(VTOTAL - 1);
    localparam logic [VW-1:0]     V_VIS_C    = VW'(V_VIS);
    localparam logic [VW-1:0]     V_SS       = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0]     V_SE       = VW'(V_VIS + V_FP + V_SYNC);
    localparam logic [PW-1:0]     PH_LAST    = PW'(CHAR_W - 1);
    localparam logic [LW-1:0]     LN_LAST    = LW'(CHAR_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(COLS * 2);

    // Raster position and its decomposition into text cell coordinates
    logic [HW-1:0]  hcnt_q, hcnt_d;
    logic [VW-1:0]  vcnt_q, vcnt_d;
    logic [PW-1:0]  ph_q, ph_d;
    logic [CLW-1:0] col_q, col_d;
    logic [LW-1:0]  ln_q, ln_d;
    logic [RW-1:0]  row_q, row_d;

    // Registered readout outputs
    logic              active_q, active_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PW-1:0]     rcnt_q, rcnt_d;
    logic [LW-1:0]     vc_q, vc_d;
    logic              fs_q, fs_d;

    // Sync delay line, stored as {hsync active, vsync active, visible} so an
    // all-zero (reset) stage means "idle, not visible"
    logic [PIPE_DLY:0][2:0] dly_q, dly_d;

    logic       h_wrap, v_wrap, at_origin, vis, hs_raw, vs_raw;
    logic [8:0] row_idx;

`ifdef VGA_TEXT_TIMING_SCROLL_EN
    localparam int         ROWS   = V_VIS / CHAR_H;
    localparam logic [8:0] ROWS_9 = 9'(ROWS);
    logic [7:0] scroll_q, scroll_d;
`else
    logic unused_scroll;
    assign unused_scroll = ^scrollRow;
`endif

    // Next-state logic for counters, scroll latch, readout and sync stages
    always_comb begin
        h_wrap    = (hcnt_q == H_LAST);
        v_wrap    = (vcnt_q == V_LAST);
        at_origin = (hcnt_q == '0) && (vcnt_q == '0);
        vis       = (hcnt_q < H_VIS_C) && (vcnt_q < V_VIS_C);
        hs_raw    = (hcnt_q >= H_SS) && (hcnt_q < H_SE);
        vs_raw    = (vcnt_q >= V_SS) && (vcnt_q < V_SE);

        hcnt_d = h_wrap ? '0 : hcnt_q + HW'(1);
        vcnt_d = vcnt_q;
        ph_d   = (ph_q == PH_LAST) ? '0 : ph_q + PW'(1);
        col_d  = (ph_q == PH_LAST) ? col_q + CLW'(1) : col_q;
        ln_d   = ln_q;
        row_d  = row_q;
        if (h_wrap) begin
            ph_d  = '0;
            col_d = '0;
            if (v_wrap) begin
                vcnt_d = '0;
                ln_d   = '0;
                row_d  = '0;
            end else begin
                vcnt_d = vcnt_q + VW'(1);
                if (ln_q == LN_LAST) begin
                    ln_d  = '0;
                    row_d = row_q + RW'(1);
                end else begin
                    ln_d = ln_q + LW'(1);
                end
            end
        end

`ifdef VGA_TEXT_TIMING_SCROLL_EN
        // The new scroll value is used by the very cycle that latches it so
        // row 0 of the frame already reflects it.
        scroll_d = scroll_q;
        if (at_origin) begin
            scroll_d = ({1'b0, scrollRow} < ROWS_9) ? scrollRow : 8'd0;
        end
        row_idx = 9'(row_q) + {1'b0, scroll_d};
        if (row_idx >= ROWS_9) begin
            row_idx = row_idx - ROWS_9;
        end
`else
        row_idx = 9'(row_q);
`endif

        active_d = vis;
        rcnt_d   = ph_q;
        vc_d     = ln_q;
        fs_d     = at_origin;
        addr_d   = addr_q;
        if (vis) begin
            addr_d = ADDR_W'(row_idx) * ROW_STRIDE
                   + ADDR_W'({col_q, 1'b0})
                   + ADDR_W'(ph_q != '0);
        end

        dly_d    = dly_q;
        dly_d[0] = {hs_raw, vs_raw, vis};
        for (int i = 1; i <= PIPE_DLY; i++) begin
            dly_d[i] = dly_q[i-1];
        end
    end

    // State update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            ph_q     <= '0;
            col_q    <= '0;
            ln_q     <= '0;
            row_q    <= '0;
            active_q <= 1'b0;
            addr_q   <= '0;
            rcnt_q   <= '0;
            vc_q     <= '0;
            fs_q     <= 1'b0;
            dly_q    <= '0;
`ifdef VGA_TEXT_TIMING_SCROLL_EN
            scroll_q <= '0;
`endif
        end else begin
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            ph_q     <= ph_d;
            col_q    <= col_d;
            ln_q     <= ln_d;
            row_q    <= row_d;
            active_q <= active_d;
            addr_q   <= addr_d;
            rcnt_q   <= rcnt_d;
            vc_q     <= vc_d;
            fs_q     <= fs_d;
            dly_q    <= dly_d;
`ifdef VGA_TEXT_TIMING_SCROLL_EN
            scroll_q <= scroll_d;
`endif
        end
    end

    assign hSync        = dly_q[PIPE_DLY][2] ? HSYNC_POL : ~HSYNC_POL;
    assign vSync        = dly_q[PIPE_DLY][1] ? VSYNC_POL : ~VSYNC_POL;
    assign nVis         = ~dly_q[PIPE_DLY][0];
    assign active       = active_q;
    assign readoutAddr  = addr_q;
    assign readoutCount = rcnt_q;
    assign vCount       = vc_q;
    assign frameStart   = fs_q;

endmodule

// File: tb/tb_vga_text_timing.sv
// Bench for vga_text_timing with a reduced raster so several frames fit in a
// short run. A division/modulo based model feeds a scoreboard queue; a table
// of hand-derived fetch addresses and a few timed sequences cover the corners.
module tb_vga_text_timing;

    localparam int HV = 32, HF = 4, HS = 8, HB = 4;
    localparam int VV = 32, VF = 2, VS = 2, VB = 3;
    localparam int CW = 8, CH = 4, PD = 3, AW = 8;
    localparam bit HPOL = 1'b1, VPOL = 1'b0;
    localparam bit H_OFF = !HPOL, V_OFF = !VPOL;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int COLS = HV / CW, ROWS = VV / CH;
    localparam int FR = HT * VT;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    scrollRow = 8'd0;
    logic          hSync, vSync, nVis, active, frameStart;
    logic [AW-1:0] readoutAddr;
    logic [2:0]    readoutCount;
    logic [1:0]    vCount;

    vga_text_timing #(
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CHAR_W(CW), .CHAR_H(CH), .HSYNC_POL(HPOL), .VSYNC_POL(VPOL),
        .PIPE_DLY(PD), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .scrollRow(scrollRow),
        .hSync(hSync), .vSync(vSync), .nVis(nVis), .active(active),
        .readoutAddr(readoutAddr), .readoutCount(readoutCount),
        .vCount(vCount), .frameStart(frameStart)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          act;
        logic [AW-1:0] addr;
        logic [2:0]    rc;
        logic [1:0]    vc;
        logic          fs;
    } reg_t;

    typedef struct {
        int   frame;
        int   h;
        int   v;
        reg_t r;
    } exp_t;

    typedef struct {
        int frame;
        int v;
        int h;
        int addr;
        int rc;
        int vc;
        int act;
    } vec_t;

    exp_t       sbq[$];
    logic [2:0] syncq[$];
    vec_t       vecs[$];

    int mh, mv, mscroll, mframe, maddr;
    int cyc, ncmp, nbad, hits;

    task automatic chk(input string name, input int got, input int want);
        ncmp++;
        if (got != want) begin
            nbad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // One clock: model the edge, push expectation, clock, pop and compare.
    task automatic tick();
        exp_t       e;
        exp_t       o;
        reg_t       got;
        logic [2:0] raw;
        bit         vis;
        logic       ehs, evs, env;
        if (rst) begin
            e.frame = -1; e.h = -1; e.v = -1; e.r = '0;
            mh = 0; mv = 0; mscroll = 0; mframe = -1; maddr = 0;
            syncq.delete();
            for (int i = 0; i <= PD; i++) syncq.push_back(3'b000);
        end else begin
            if (mh == 0 && mv == 0) begin
                mframe++;
`ifdef VGA_TEXT_TIMING_SCROLL_EN
                mscroll = (int'(scrollRow) < ROWS) ? int'(scrollRow) : 0;
`else
                mscroll = 0;
`endif
            end
            vis = (mh < HV) && (mv < VV);
            if (vis)
                maddr = ((((mv / CH) + mscroll) % ROWS) * COLS * 2
                         + (mh / CW) * 2 + (((mh % CW) != 0) ? 1 : 0)) % (1 << AW);
            e.frame = mframe; e.h = mh; e.v = mv;
            e.r.act  = vis;
            e.r.addr = AW'(maddr);
            e.r.rc   = 3'(mh % CW);
            e.r.vc   = 2'(mv % CH);
            e.r.fs   = (mh == 0 && mv == 0);
            raw[2] = (mh >= HV + HF) && (mh < HV + HF + HS);
            raw[1] = (mv >= VV + VF) && (mv < VV + VF + VS);
            raw[0] = vis;
            syncq.push_back(raw);
            void'(syncq.pop_front());
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end
        end
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        o = sbq.pop_front();
        got.act = active; got.addr = readoutAddr; got.rc = readoutCount;
        got.vc = vCount; got.fs = frameStart;
        ncmp++;
        if (got !== o.r) begin
            nbad++;
            $display("FAIL sb cyc=%0d pos=(%0d,%0d) got act=%0b addr=%0d rc=%0d vc=%0d fs=%0b want act=%0b addr=%0d rc=%0d vc=%0d fs=%0b",
                     cyc, o.h, o.v, got.act, got.addr, got.rc, got.vc, got.fs,
                     o.r.act, o.r.addr, o.r.rc, o.r.vc, o.r.fs);
        end
        ehs = syncq[0][2] ? HPOL : H_OFF;
        evs = syncq[0][1] ? VPOL : V_OFF;
        env = !syncq[0][0];
        ncmp++;
        if ({hSync, vSync, nVis} !== {ehs, evs, env}) begin
            nbad++;
            $display("FAIL sync cyc=%0d got hs=%0b vs=%0b nvis=%0b want hs=%0b vs=%0b nvis=%0b",
                     cyc, hSync, vSync, nVis, ehs, evs, env);
        end
        foreach (vecs[i]) begin
            if (vecs[i].frame == o.frame && vecs[i].v == o.v && vecs[i].h == o.h) begin
                hits++;
                ncmp++;
                if (int'(readoutAddr) != vecs[i].addr || int'(readoutCount) != vecs[i].rc ||
                    int'(vCount) != vecs[i].vc || int'(active) != vecs[i].act) begin
                    nbad++;
                    $display("FAIL vec f%0d v%0d h%0d got addr=%0d rc=%0d vc=%0d act=%0b want addr=%0d rc=%0d vc=%0d act=%0d",
                             o.frame, o.v, o.h, readoutAddr, readoutCount, vCount, active,
                             vecs[i].addr, vecs[i].rc, vecs[i].vc, vecs[i].act);
                end
            end
        end
    endtask

    int  hs_first, hs_len, vs_first, vs_len, fs1, fs2, nvl;
    bit  hs_done, vs_done;

    initial begin
        // {frame, line, pixel, addr, phase, scanline, active}
        vecs.push_back('{0, 0, 0, 0, 0, 0, 1});
        vecs.push_back('{0, 0, 1, 1, 1, 0, 1});
        vecs.push_back('{0, 0, 5, 1, 5, 0, 1});
        vecs.push_back('{0, 0, 8, 2, 0, 0, 1});
        vecs.push_back('{0, 0, 31, 7, 7, 0, 1});
        vecs.push_back('{0, 0, 32, 7, 0, 0, 0});
        vecs.push_back('{0, 3, 0, 0, 0, 3, 1});
        vecs.push_back('{0, 4, 9, 11, 1, 0, 1});
        vecs.push_back('{0, 31, 31, 63, 7, 3, 1});
        vecs.push_back('{0, 32, 0, 63, 0, 0, 0});
`ifdef VGA_TEXT_TIMING_SCROLL_EN
        vecs.push_back('{1, 0, 0, 24, 0, 0, 1});
        vecs.push_back('{1, 20, 17, 5, 1, 0, 1});
        vecs.push_back('{2, 0, 1, 57, 1, 0, 1});
        vecs.push_back('{2, 4, 0, 0, 0, 0, 1});
`else
        vecs.push_back('{1, 0, 0, 0, 0, 0, 1});
        vecs.push_back('{1, 20, 17, 45, 1, 0, 1});
        vecs.push_back('{2, 0, 1, 1, 1, 0, 1});
        vecs.push_back('{2, 4, 0, 8, 0, 0, 1});
`endif
        vecs.push_back('{3, 0, 0, 0, 0, 0, 1});
        vecs.push_back('{3, 4, 3, 9, 3, 0, 1});

        ncmp = 0; nbad = 0; hits = 0; cyc = 0;
        hs_first = -1; hs_len = 0; vs_first = -1; vs_len = 0;
        fs1 = -1; fs2 = -1; nvl = 0; hs_done = 0; vs_done = 0;

        rst = 1'b1;
        repeat (3) tick();
        chk("rst_hsync", int'(hSync), int'(H_OFF));
        chk("rst_nvis", int'(nVis), 1);

        rst = 1'b0;
        cyc = 0;
        for (int t = 1; t <= 4 * FR; t++) begin
            if (mh == 0 && mv == 10 && mframe == 0) scrollRow = 8'd3;
            if (mh == 0 && mv == 20 && mframe == 1) scrollRow = 8'd7;
            if (mh == 0 && mv == 10 && mframe == 2) scrollRow = 8'd9;
            tick();
            if (hSync == HPOL) begin
                if (hs_first < 0) hs_first = cyc;
                if (!hs_done) hs_len++;
            end else if (hs_first >= 0) hs_done = 1;
            if (vSync == VPOL) begin
                if (vs_first < 0) vs_first = cyc;
                if (!vs_done) vs_len++;
            end else if (vs_first >= 0) vs_done = 1;
            if (frameStart) begin
                if (fs1 < 0) fs1 = cyc;
                else if (fs2 < 0) fs2 = cyc;
            end
            if (cyc <= FR && !nVis) nvl++;
        end

        chk("hs_first", hs_first, HV + HF + 1 + PD);
        chk("hs_len", hs_len, HS);
        chk("vs_first", vs_first, (VV + VF) * HT + 1 + PD);
        chk("vs_len", vs_len, VS * HT);
        chk("fs_first", fs1, 1);
        chk("fs_period", fs2 - fs1, FR);
        chk("nvis_low", nvl, HV * VV);
        chk("vec_hits", hits, vecs.size());

        // Reset in the middle of a visible line
        for (int k = 0; k < FR && !(mh == 20 && mv == 13); k++) tick();
        chk("seek_pos", int'(mh == 20 && mv == 13), 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_hsync", int'(hSync), int'(H_OFF));
        chk("mid_rst_vsync", int'(vSync), int'(V_OFF));
        chk("mid_rst_nvis", int'(nVis), 1);
        chk("mid_rst_active", int'(active), 0);
        chk("mid_rst_addr", int'(readoutAddr), 0);
        chk("mid_rst_rc", int'(readoutCount), 0);
        chk("mid_rst_vc", int'(vCount), 0);
        chk("mid_rst_fs", int'(frameStart), 0);
        rst = 1'b0;
        tick();
        chk("post_rst_fs_hi", int'(frameStart), 1);
        chk("post_rst_addr", int'(readoutAddr), 0);
        tick();
        chk("post_rst_fs_lo", int'(frameStart), 0);
        chk("post_rst_rc", int'(readoutCount), 1);
        repeat (200) tick();

        $display("test done: total=%0d bad=%0d", ncmp, nbad);
        $finish;
    end

endmodule

// File: doc/vga_text_timing.md
VGA_TEXT_TIMING -- requirements
Module: vga_text_timing

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- H_VIS 640: visible pixels per line
- H_FP 16: horizontal front porch, clocks
- H_SYNC 96: horizontal sync width, clocks
- H_BP 48: horizontal back porch, clocks
- V_VIS 480: visible lines per frame
- V_FP 10: vertical front porch, lines
- V_SYNC 2: vertical sync width, lines
- V_BP 33: vertical back porch, lines
- CHAR_W 8: character cell width, clocks
- CHAR_H 16: character cell height, lines
- HSYNC_POL 0: active level of hSync
- VSYNC_POL 0: active level of vSync
- PIPE_DLY 8: clocks by which sync/nVis lag the readout outputs
- ADDR_W 13: VRAM address width
REQ-002 Derived values SHALL be: HTOTAL=H_VIS+H_FP+H_SYNC+H_BP, VTOTAL=V_VIS+V_FP+V_SYNC+V_BP, COLS=H_VIS/CHAR_W, ROWS=V_VIS/CHAR_H.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  dot clock; the block's only clock
- rst  in  1  reset, synchronous, active-high
- scrollRow  in  8  first text row to display
- hSync  out  1  horizontal sync at HSYNC_POL
- vSync  out  1  vertical sync at VSYNC_POL
- nVis  out  1  low while the pixel is visible
- active  out  1  readout window valid
- readoutAddr  out  ADDR_W  VRAM fetch address
- readoutCount  out  clog2(CHAR_W)  phase within the cell
- vCount  out  clog2(CHAR_H)  scanline within the text row
- frameStart  out  1  one-clock pulse at h=0, v=0

Function
REQ-004 The internal counters SHALL be hCount 0..HTOTAL-1 and vCount 0..VTOTAL-1; vCount increments when hCount wraps; both counters wrap to 0 together at the end of the frame.
REQ-005 Visibility (vis) SHALL be defined as hCount<H_VIS and vCount<V_VIS; the readout window SHALL equal the visible window.
REQ-006 hSync SHALL be at HSYNC_POL for hCount in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC) and at the inverse level otherwise; vSync SHALL be at VSYNC_POL for vCount in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC) and at the inverse level otherwise.
REQ-007 active, readoutAddr, readoutCount, vCount and frameStart SHALL be registered with 1 clock of latency from the counters.
REQ-008 hSync, vSync and nVis SHALL pass through a PIPE_DLY-stage shift register, giving PIPE_DLY+1 clocks of total latency; PIPE_DLY=0 SHALL mean no added stages.
REQ-009 Within a cell, readoutCount SHALL equal hCount mod CHAR_W, and the vCount output SHALL equal (internal vCount) mod CHAR_H.
REQ-010 In a cell at column c of displayed row r, readoutAddr SHALL be:
- base(r)+2c at phase 0 (character byte)
- base(r)+2c+1 at phase 1 (attribute byte)
- held at the phase-1 value for phases 2..CHAR_W-1
REQ-011 base(r) SHALL equal ((r+scrollLat) mod ROWS)*COLS*2, truncated to ADDR_W bits.
REQ-012 Outside the readout window, active SHALL be 0 and readoutAddr SHALL hold its last value.
REQ-013 scrollLat SHALL be loaded from scrollRow only on the cycle with hCount=0 and vCount=0; a scrollRow value >= ROWS SHALL load 0; changes to scrollRow mid-frame SHALL have no effect until the next frame.

Reset
REQ-014 While rst=1 at a clock edge, the following SHALL be cleared to 0: hCount, vCount, scrollLat and every delay stage.
REQ-015 On the clock after rst is sampled high, outputs SHALL be:
- hSync=~HSYNC_POL, vSync=~VSYNC_POL
- nVis=1, active=0, readoutAddr=0, readoutCount=0, vCount=0, frameStart=0
REQ-016 Asserting rst mid-line or mid-frame SHALL abandon the current frame; counting SHALL restart from h=0, v=0 on the first clock after rst goes low, and frameStart SHALL pulse one clock later.

Configuration
REQ-017 With macro VGA_TEXT_TIMING_SCROLL_EN defined, scrolling SHALL behave as in REQ-011 and REQ-013.
REQ-018 Without VGA_TEXT_TIMING_SCROLL_EN, the scrollRow port SHALL remain present but be ignored, scrollLat SHALL be constant 0, and no scroll register or modulo logic SHALL be synthesised.

Verification (default parameters; reset released at T=0)
REQ-019 Horizontal timing: run free -> hSync is low for 96 clocks beginning at clock 665 (656+1+8), with a period of 800 clocks; nVis is low for 640 clocks per visible line.
REQ-020 Vertical timing: run free -> vSync is low for 1600 clocks starting at line 490; frameStart repeats every 420000 clocks.
REQ-021 Readout order, scrollRow=0: line 0 fetches 0,1,(held),2,3,... ending at 158,159; line 15 repeats row 0 with vCount=15; line 16 starts at 160.
REQ-022 Scroll wrap: scrollRow=29 before frameStart -> text row 0 fetches from 4640, text row 1 fetches from 0; scrollRow=31 -> behaves as 0; macro undefined -> scrollRow=29 behaves as 0.
REQ-023 Scroll change mid-frame: scrollRow changed from 0 to 5 at line 100 -> the current frame is unaffected; the next frame's row 0 starts at 800.
REQ-024 Reset mid-operation: rst asserted for 1 clock at h=300, v=200 -> next clock shows the REQ-015 values; frameStart is 1 exactly 2 clocks after rst falls.
